// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the 8-bit-instruction core.
// Imported by the decoder and by fetch_ctrl.
//   opcode_t    : 4-bit opcode encoding (LB=0 ... HALT=14, TBA=15)
//   format_t    : instruction format class
//   fsm_state_t : fetch_ctrl sequencer states
package isa_pkg;

  typedef enum logic [3:0] {
    OP_LB   = 4'd0,
    OP_LHB  = 4'd1,
    OP_STR  = 4'd2,
    OP_LIM  = 4'd3,
    OP_MVB  = 4'd4,
    OP_MVF  = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_SFT  = 4'd8,
    OP_INC  = 4'd9,
    OP_JMP  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BEQ  = 4'd12,
    OP_BLT  = 4'd13,
    OP_HALT = 4'd14,
    OP_TBA  = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    FMT_C,  // control flow
    FMT_I,  // immediate / register ALU
    FMT_M,  // memory
    FMT_X   // misc / reserved
  } format_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } fsm_state_t;

  // Instruction classes used by the sequencer.
  function automatic logic is_mem_op(opcode_t op);
    return (op == OP_LB) || (op == OP_LHB) || (op == OP_STR);
  endfunction

  function automatic format_t op_format(opcode_t op);
    case (op)
      OP_LB, OP_LHB, OP_STR:           return FMT_M;
      OP_JMP, OP_BNE, OP_BEQ, OP_BLT,
      OP_HALT:                         return FMT_C;
      OP_TBA:                          return FMT_X;
      default:                         return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bus between the fetch sequencer and the core around it.
//   start        : run request into the sequencer
//   pc           : fetch address to the instruction ROM
//   opcode       : decoded opcode for the instruction at pc
//   jmp_loc      : decoded jump/branch target (16 bits)
//   branch_taken : ALU condition for BNE/BEQ/BLT
//   mem_req/we   : memory request / store flag; mem_ack completion pulse
//   reg_we       : register-file write strobe
//   ir_op        : latched opcode of the instruction in flight
//   busy/halted  : status
// master = sequencer side, slave = core/environment side.
interface fetch_ctrl_if #(parameter int PC_W = 16);
  logic            start;
  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;
  logic [15:0]     jmp_loc;
  logic            branch_taken;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic            reg_we;
  logic [3:0]      ir_op;
  logic            busy;
  logic            halted;

  modport master (
    input  start, opcode, jmp_loc, branch_taken, mem_ack,
    output pc, mem_req, mem_we, reg_we, ir_op, busy, halted
  );

  modport slave (
    output start, opcode, jmp_loc, branch_taken, mem_ack,
    input  pc, mem_req, mem_we, reg_we, ir_op, busy, halted
  );
endinterface

// File: rtl/fetch_ctrl_retire_counter.sv
// retire_counter: free-running 32-bit count of retired instructions.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   inc        : one-cycle retire pulse
//   cnt        : current count, wraps at 2^32
module retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= cnt + 32'd1;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch/execute/memory sequencer for the
// 8-bit-instruction core. Owns the PC, latches opcode and jump target in
// FETCH, resolves ALU / jump / branch / NOP in EXEC, and waits in MEM for
// mem_ack on LB/LHB/STR. HALT is sticky until reset.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_ctrl_if.master (see interface header)
//   retire_cnt : retired-instruction count, only when the macro
//                FETCH_CTRL_RETIRE_CNT_EN is defined
// All bus outputs come straight from flops; they are loaded from the
// next-state decode so they line up with the state they describe.
module fetch_ctrl
  import isa_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_ctrl_if.master    bus
`ifdef FETCH_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt
`endif
);

  fsm_state_t      state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, target_q;
  opcode_t         ir_q;
  logic            reg_we_q, reg_we_nxt;
  logic            mem_req_q, mem_we_q, mem_we_nxt;
  logic            busy_q, halted_q;
  logic            retire;

  assign pc_inc = pc_q + PC_W'(1);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---- next state, next PC, strobes ----
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    reg_we_nxt = 1'b0;
    mem_we_nxt = mem_we_q;
    retire     = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
        case (ir_q)
          OP_LIM, OP_MVB, OP_MVF, OP_ADD, OP_SUB, OP_SFT, OP_INC: begin
            reg_we_nxt = 1'b1;
            pc_nxt     = pc_inc;
          end
          OP_JMP: pc_nxt = target_q;
          OP_BNE, OP_BEQ, OP_BLT:
            pc_nxt = bus.branch_taken ? target_q : pc_inc;
          OP_LB, OP_LHB, OP_STR: begin
            state_nxt  = ST_MEM;
            retire     = 1'b0;
            mem_we_nxt = (ir_q == OP_STR);
          end
          OP_HALT: begin
            state_nxt = ST_HALT;
            retire    = 1'b0;
          end
          default: pc_nxt = pc_inc;  // TBA behaves as a NOP
        endcase
      end
      ST_MEM: begin
        // Wait indefinitely; the ack cycle retires the access.
        if (bus.mem_ack) begin
          state_nxt  = ST_FETCH;
          pc_nxt     = pc_inc;
          reg_we_nxt = (ir_q != OP_STR);
          retire     = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- datapath and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= OP_LB;
      target_q  <= '0;
      reg_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (state == ST_FETCH) begin
        ir_q     <= opcode_t'(bus.opcode);
        target_q <= bus.jmp_loc[PC_W-1:0];
      end
      reg_we_q  <= reg_we_nxt;
      mem_req_q <= (state_nxt == ST_MEM);
      mem_we_q  <= mem_we_nxt;
      busy_q    <= (state_nxt == ST_FETCH) || (state_nxt == ST_EXEC) ||
                   (state_nxt == ST_MEM);
      halted_q  <= (state_nxt == ST_HALT);
    end
  end

  assign bus.pc      = pc_q;
  assign bus.ir_op   = ir_q;
  assign bus.reg_we  = reg_we_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;

`ifdef FETCH_CTRL_RETIRE_CNT_EN
  retire_counter u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .cnt   (retire_cnt)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl. A small program ROM
// feeds dut (PC_W=16); each retired instruction shows up as a PC change,
// which a monitor checks against a queue of hand-computed expectations
// (new pc, reg_we pulses, ir_op, latency, mem_req cycles, mem_we).
// Halt, async reset mid-MEM and a PC_W=4 wrap instance are checked directly.
module tb_fetch_ctrl;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.PC_W(16)) bus ();
  fetch_ctrl_if #(.PC_W(4))  bus2 ();

`ifdef FETCH_CTRL_RETIRE_CNT_EN
  logic [31:0] rc1, rc2;
`endif

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    , .retire_cnt(rc1)
`endif
  );

  fetch_ctrl #(.PC_W(4), .RESET_PC(4'hF)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    , .retire_cnt(rc2)
`endif
  );

  // ---- program ROM for dut ----
  logic [3:0]  rom_op  [64];
  logic [15:0] rom_tgt [64];
  logic        rom_bt  [64];
  int          rom_ack [64];

  assign bus.opcode       = rom_op[bus.pc[5:0]];
  assign bus.jmp_loc      = rom_tgt[bus.pc[5:0]];
  assign bus.branch_taken = rom_bt[bus.pc[5:0]];

  // dut2: ADD at 15 (wraps to 0), JMP 0x00F3 at 0 (truncates to 3), HALT.
  assign bus2.opcode       = (bus2.pc == 4'hF) ? 4'(OP_ADD) :
                             (bus2.pc == 4'h0) ? 4'(OP_JMP) : 4'(OP_HALT);
  assign bus2.jmp_loc      = 16'h00F3;
  assign bus2.branch_taken = 1'b0;
  assign bus2.mem_ack      = 1'b0;

  // ---- counters and check helper ----
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- memory responder: ack after rom_ack[pc] cycles of mem_req ----
  int an = 0;
  always @(negedge clk) begin
    if (rst_n && bus.mem_req) begin
      an++;
      bus.mem_ack = (an == rom_ack[bus.pc[5:0]]);
    end else begin
      an = 0;
      bus.mem_ack = 1'b0;
    end
  end

  // ---- scoreboard ----
  typedef struct {
    logic [15:0] pc;
    int          rw;
    logic [3:0]  op;
    int          lat;
    int          mc;
    logic        mw;
  } exp_t;
  exp_t q[$];

  task automatic push(input logic [15:0] pc, input int rw, input opcode_t op,
                      input int lat, input int mc, input logic mw);
    exp_t e;
    e.pc = pc; e.rw = rw; e.op = op; e.lat = lat; e.mc = mc; e.mw = mw;
    q.push_back(e);
  endtask

  bit          mon_en = 1'b1;
  logic [15:0] pc_prev = '0;
  int          last_cyc = 0;
  int          mc = 0;
  int          rw_cnt = 0;
  logic        mw_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pc_prev  = bus.pc;
      last_cyc = cyc;
      mc       = 0;
      rw_cnt   = 0;
    end else begin
      if (!bus.busy) last_cyc = cyc;
      if (bus.mem_req) begin
        mc++;
        mw_seen = bus.mem_we;
      end
      if (bus.reg_we) rw_cnt++;
      if (bus.pc != pc_prev) begin
        if (mon_en) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", 32'(bus.pc), 32'(pc_prev));
          end else begin
            e = q.pop_front();
            chk("sb_pc",      32'(bus.pc),       32'(e.pc));
            chk("sb_reg_we",  32'(rw_cnt),       32'(e.rw));
            chk("sb_ir_op",   32'(bus.ir_op),    32'(e.op));
            chk("sb_latency", 32'(cyc - last_cyc), 32'(e.lat));
            chk("sb_mem_cyc", 32'(mc),           32'(e.mc));
            if (e.mc > 0) chk("sb_mem_we", 32'(mw_seen), 32'(e.mw));
          end
        end
        pc_prev  = bus.pc;
        last_cyc = cyc;
        mc       = 0;
        rw_cnt   = 0;
      end
    end
  end

  // ---- stimulus ----
  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_op[i]  = OP_HALT;
      rom_tgt[i] = 16'hBEEF;
      rom_bt[i]  = 1'b0;
      rom_ack[i] = 1;
    end
    rom_op[0]  = OP_ADD;
    rom_op[1]  = OP_SUB;
    rom_op[2]  = OP_INC;
    rom_op[3]  = OP_LIM;
    rom_op[4]  = OP_TBA;
    rom_op[5]  = OP_JMP; rom_tgt[5]  = 16'd20;
    rom_op[20] = OP_BNE; rom_tgt[20] = 16'd8;  rom_bt[20] = 1'b1;
    rom_op[8]  = OP_BEQ; rom_tgt[8]  = 16'd30; rom_bt[8]  = 1'b1;
    rom_op[30] = OP_SFT;
    rom_op[31] = OP_BEQ; rom_tgt[31] = 16'd50; rom_bt[31] = 1'b0;
    rom_op[32] = OP_LB;  rom_ack[32] = 3;
    rom_op[33] = OP_STR; rom_ack[33] = 1;
    rom_op[34] = OP_LHB; rom_ack[34] = 2;
    rom_op[35] = OP_MVB;
    rom_op[36] = OP_MVF;
    rom_op[37] = OP_HALT;

    bus.start  = 1'b0;
    bus2.start = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_pc",      32'(bus.pc), 32'd0);
    chk("rst_ir_op",   32'(bus.ir_op), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_halted",  32'(bus.halted), 32'd0);
    chk("rst_reg_we",  32'(bus.reg_we), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
    chk("rst_pc_w4",   32'(bus2.pc), 32'd15);
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    chk("rst_retire",  rc1, 32'd0);
`endif

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", 32'(bus.busy), 32'd0);

    // expected retire sequence (pc after, reg_we pulses, op, latency, mem cycles, mem_we)
    push(16'd1,  1, OP_ADD, 3, 0, 1'b0);
    push(16'd2,  1, OP_SUB, 2, 0, 1'b0);
    push(16'd3,  1, OP_INC, 2, 0, 1'b0);
    push(16'd4,  1, OP_LIM, 2, 0, 1'b0);
    push(16'd5,  0, OP_TBA, 2, 0, 1'b0);
    push(16'd20, 0, OP_JMP, 2, 0, 1'b0);
    push(16'd8,  0, OP_BNE, 2, 0, 1'b0);
    push(16'd30, 0, OP_BEQ, 2, 0, 1'b0);
    push(16'd31, 1, OP_SFT, 2, 0, 1'b0);
    push(16'd32, 0, OP_BEQ, 2, 0, 1'b0);
    push(16'd33, 1, OP_LB,  5, 3, 1'b0);
    push(16'd34, 0, OP_STR, 3, 1, 1'b1);
    push(16'd35, 1, OP_LHB, 4, 2, 1'b0);
    push(16'd36, 1, OP_MVB, 2, 0, 1'b0);
    push(16'd37, 1, OP_MVF, 2, 0, 1'b0);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;  // dropping start while busy must not stop the run
    for (int i = 0; i < 300 && !bus.halted; i++) @(negedge clk);
    chk("halt_reached", 32'(bus.halted), 32'd1);
    chk("halt_pc",      32'(bus.pc), 32'd37);
    chk("halt_busy",    32'(bus.busy), 32'd0);
    chk("halt_ir_op",   32'(bus.ir_op), 32'(OP_HALT));
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    chk("retire_cnt",   rc1, 32'd15);
`endif

    // HALT is sticky; start toggling is ignored
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.start = i[0];
      if (i % 10 == 9) begin
        chk("halt_hold_pc",     32'(bus.pc), 32'd37);
        chk("halt_hold_halted", 32'(bus.halted), 32'd1);
        chk("halt_hold_busy",   32'(bus.busy), 32'd0);
      end
    end
    bus.start = 1'b0;
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    chk("retire_cnt_halt", rc1, 32'd15);
`endif
    chk("sb_drained", 32'(q.size()), 32'd0);

    // async reset in the middle of an LB that is never acked
    mon_en      = 1'b0;
    rom_op[0]   = OP_LB;
    rom_ack[0]  = 0;
    rst_n       = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_pc",     32'(bus.pc), 32'd0);
    chk("rst2_halted", 32'(bus.halted), 32'd0);
    bus.start = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
    chk("lb_mem_req", 32'(bus.mem_req), 32'd1);
    repeat (2) @(negedge clk);
    chk("lb_wait_req", 32'(bus.mem_req), 32'd1);
    chk("lb_wait_rw",  32'(bus.reg_we), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midmem_pc",      32'(bus.pc), 32'd0);
    chk("midmem_busy",    32'(bus.busy), 32'd0);
    chk("midmem_mem_req", 32'(bus.mem_req), 32'd0);
    chk("midmem_reg_we",  32'(bus.reg_we), 32'd0);
    chk("midmem_ir_op",   32'(bus.ir_op), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",   32'(bus.busy), 32'd0);
    chk("post_rst_reg_we", 32'(bus.reg_we), 32'd0);
    chk("post_rst_pc",     32'(bus.pc), 32'd0);

    // PC_W=4: ADD at 15 wraps to 0; JMP 0x00F3 truncates to 3; HALT at 3
    chk("w4_pc_start", 32'(bus2.pc), 32'd15);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("w4_wrap_pc",  32'(bus2.pc), 32'd0);
    chk("w4_wrap_rw",  32'(bus2.reg_we), 32'd1);
    repeat (2) @(negedge clk);
    chk("w4_jmp_pc",   32'(bus2.pc), 32'd3);
    repeat (3) @(negedge clk);
    chk("w4_halted",   32'(bus2.halted), 32'd1);
    chk("w4_halt_pc",  32'(bus2.pc), 32'd3);
`ifdef FETCH_CTRL_RETIRE_CNT_EN
    chk("w4_retire",   rc2, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Multi-cycle sequencer for the 8-bit-instruction core. It owns the program counter and drives it into the instruction ROM/decoder. It consumes the decoded opcode and jump target, and steps each instruction through fetch, execute and optional memory phases. It generates register-write, memory-request and halt controls, and handles JMP, conditional branches and HALT.

Parameters:
PC_W, 16, program counter width; PC wraps modulo 2^PC_W.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level; leaves IDLE when 1.
pc  out  PC_W  current fetch address to the instruction ROM.
opcode  in  4  decoded opcode for the instruction at pc.
jmp_loc  in  16  decoded jump/branch target; low PC_W bits used.
branch_taken  in  1  ALU condition result for BNE/BEQ/BLT; valid in EXEC.
mem_req  out  1  memory access request for LB/LHB/STR.
mem_we  out  1  1 = store (STR), 0 = load; valid while mem_req=1.
mem_ack  in  1  memory completion; single-cycle pulse.
reg_we  out  1  register-file write strobe, one cycle.
ir_op  out  4  latched opcode of the instruction in flight.
busy  out  1  1 in any state except IDLE and HALT.
halted  out  1  1 in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, ir_op=0.
  - mem_req, mem_we, reg_we, busy and halted all 0.
  - Reset mid-instruction abandons it with no write.
- States: IDLE, FETCH, EXEC, MEM, HALT. All outputs are registered from the state and latched fields.
- IDLE -> FETCH when start=1; otherwise remain in IDLE.
- FETCH (1 cycle):
  - ir_op <= opcode.
  - Latch jmp_loc into an internal target register.
  - -> EXEC.
- EXEC (1 cycle), by ir_op:
  - LIM, MVB, MVF, ADD, SUB, SFT, INC: reg_we=1 this cycle; pc <= pc+1; -> FETCH.
  - JMP: pc <= target; -> FETCH.
  - BNE, BEQ, BLT: pc <= branch_taken ? target : pc+1; -> FETCH.
  - LB, LHB, STR: -> MEM. mem_we <= (ir_op==STR).
  - HALT: -> HALT; pc unchanged.
  - TBA (1111): NOP; pc <= pc+1; -> FETCH.
- MEM:
  - mem_req=1, held until mem_ack=1.
  - On the ack cycle: reg_we=1 if LB/LHB; pc <= pc+1; -> FETCH.
  - mem_req drops in the cycle after ack.
  - A mem_ack outside MEM is ignored.
  - No timeout: MEM waits indefinitely.
- HALT: halted=1, busy=0; start is ignored. Only reset exits HALT.
- Latency:
  - ALU, jump, branch and NOP instructions: 2 cycles.
  - Memory instructions: 3 cycles minimum; ack in the first MEM cycle gives 3 cycles.
- Arithmetic: pc+1 is PC_W bits wide and wraps from all-ones to 0. The target is truncated to PC_W bits.
- reg_we is never asserted in the same cycle as mem_req rising. At most one reg_we pulse is issued per instruction.
- start deasserting while busy has no effect; the sequence keeps running.

Optional Feature:
Macro FETCH_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments by 1 on each instruction completion: the EXEC exit to FETCH, or the MEM ack.
  - HALT does not count.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package isa_pkg holds:
  - opcode_t enum (4-bit: LB=0 ... HALT=14, TBA=15).
  - format_t enum (C, I, M, X).
  - fsm_state_t enum.
- The decoder and this block both import isa_pkg.
- One natural sub-module: retire_counter, instantiated only under FETCH_CTRL_RETIRE_CNT_EN.
- Next-PC selection stays inline.

Test Plan:
- Reset then start=1, program ADD, SUB, INC at pc 0..2 -> reg_we pulses at cycles 2, 4, 6 after start; pc steps 0→1→2→3.
- JMP with jmp_loc=20 at pc 5 -> pc=20 after EXEC; reg_we stays 0.
- BEQ at pc 8, jmp_loc=30:
  - branch_taken=1 -> pc=30.
  - Repeat with branch_taken=0 -> pc=9.
- LB at pc 0, mem_ack delayed 3 cycles -> mem_req high 3 cycles with mem_we=0; reg_we in the ack cycle; pc=1. Repeat with STR -> mem_we=1 and no reg_we.
- HALT at pc 4 -> halted=1, busy=0, pc stays 4 for 50 cycles with start toggling. Then assert rst_n=0 while in MEM of an LB -> immediate IDLE, pc=0, no reg_we.
- PC_W=4, pc=15 with ADD -> pc wraps to 0. With FETCH_CTRL_RETIRE_CNT_EN defined, retire_cnt matches the count of completed instructions; HALT does not increment it.
